clasificador_escritor: RTL and testbench
========================================

Name: clasificador_escritor

Overview:
Ingress writer that feeds the four class FIFOs drained by the downstream round-robin arbiter. It accepts a single stream of words (format [11:10] class, [9:8] destination, [7:0] data) over a valid/ready handshake. Each word is steered into the FIFO selected by its class field, honouring each FIFO's almost_full backpressure through a one-word holding register. It also keeps per-class push counters for debug and bench checking.

Parameters:
WORD_SIZE, 12, width of a FIFO word; class field is [WORD_SIZE-1:WORD_SIZE-2]
CNT_WIDTH, 8, width of each per-class push counter
STALL_LIMIT, 16, consecutive stalled cycles before timeout (used only with the optional feature)

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  WORD_SIZE  incoming word
valid_in  input  1  data_in is valid this cycle
ready_out  output  1  block can accept data_in this cycle (combinational)
fifos_almost_full  input  4  almost_full flags of class FIFOs 0..3
fifos_push  output  4  one-hot push strobe to class FIFOs, registered
fifo_data_out0..3  output  WORD_SIZE each  write data to class FIFO 0..3, registered
push_count0..3  output  CNT_WIDTH each  number of words pushed per class, wraps modulo 2^CNT_WIDTH
idle  output  1  high when holding register is empty and no push is in flight
drop_pulse  output  1  one-cycle pulse when a word is discarded (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (reset=0, asynchronous): fifos_push=0, all fifo_data_outN=0, push_countN=0, hold_valid=0, hold_data=0, stall_cnt=0, drop_pulse=0, state=EMPTY. Release is synchronised to the next clk edge.
- Holding register: hold_data, hold_valid. Target class c = hold_data[WORD_SIZE-1:WORD_SIZE-2].
- States (derived from hold_valid and flags):
  - EMPTY: hold_valid=0.
  - LOADED: hold_valid=1 and fifos_almost_full[c]=0.
  - STALLED: hold_valid=1 and fifos_almost_full[c]=1.
- ready_out = !hold_valid | !fifos_almost_full[c]; it is 1 in EMPTY and LOADED, 0 in STALLED.
- Each edge:
  - fifos_push defaults to 0.
  - In LOADED: fifos_push[c]<=1, fifo_data_out_c<=hold_data, push_count_c increments.
  - If valid_in & ready_out: hold_data<=data_in and hold_valid<=1. Otherwise, after a LOADED push, hold_valid<=0.
- Latency: a word accepted at edge N is presented with its push strobe in the cycle after edge N+1, provided its FIFO is not almost full. Sustained throughput is one word per cycle.
- Only one bit of fifos_push is ever high. Data outputs of non-pushed classes hold their last value.
- STALLED: the word is retained indefinitely and ready_out stays 0. It leaves as soon as fifos_almost_full[c] drops, and is pushed on that edge.
- Simultaneous accept and push in LOADED: the new word replaces the held word on the same edge; no bubble.
- valid_in while ready_out=0: the word is ignored, and upstream must hold it.
- Destination and data fields pass through unmodified.
- idle = !hold_valid & (fifos_push==0).

Optional Feature:
STALL_TIMEOUT_EN
- Defined: stall_cnt increments every cycle in STALLED and clears otherwise. When stall_cnt reaches STALL_LIMIT-1 while STALLED:
  - the held word is discarded (hold_valid<=0, no push, counter unchanged);
  - drop_pulse<=1 for one cycle;
  - stall_cnt<=0;
  - ready_out is still 0 that cycle.
- Not defined: no stall counter, drop_pulse is constant 0, and stalls last until backpressure clears.

Test Plan:
1. Reset low mid-stream with hold_valid=1 -> all outputs 0, idle=1, push_count0..3=0 immediately (asynchronous), no push after release.
2. Back-to-back words 0x0A5, 0x4B6, 0x8C7, 0xCD8 with valid_in=1 and no almost_full -> fifos_push 0001, 0010, 0100, 1000 on consecutive cycles; each fifo_data_outN equals its word; each push_countN=1.
3. fifos_almost_full=0010, send 0x412 -> ready_out=0 next cycle and no push. Clear the flag after 5 cycles -> fifos_push=0010, fifo_data_out1=0x412 the following cycle.
4. 256 words of class 3 -> push_count3 wraps to 0; other counters stay 0.
5. valid_in=1 while STALLED with data 0x0FF -> word not accepted; after the stall clears it is accepted and pushed to FIFO0 exactly once.
6. (STALL_TIMEOUT_EN, STALL_LIMIT=16) fifos_almost_full=1111 held with word 0xC01 -> drop_pulse=1 after 16 stalled cycles, no push, push_count3 unchanged, ready_out=1 the next cycle.

Source files
------------

// File: rtl/clasificador_escritor.sv
// Ingress writer: steers a valid/ready word stream into four class FIFOs through a one-word holding register.
// Optional stall timeout that discards a word stuck behind almost_full: define STALL_TIMEOUT_EN.
module clasificador_escritor #(
    parameter int WORD_SIZE   = 12,
    parameter int CNT_WIDTH   = 8,
    parameter int STALL_LIMIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [3:0]           fifos_almost_full,
    output logic [3:0]           fifos_push,
    output logic [WORD_SIZE-1:0] fifo_data_out0,
    output logic [WORD_SIZE-1:0] fifo_data_out1,
    output logic [WORD_SIZE-1:0] fifo_data_out2,
    output logic [WORD_SIZE-1:0] fifo_data_out3,
    output logic [CNT_WIDTH-1:0] push_count0,
    output logic [CNT_WIDTH-1:0] push_count1,
    output logic [CNT_WIDTH-1:0] push_count2,
    output logic [CNT_WIDTH-1:0] push_count3,
    output logic                 idle,
    output logic                 drop_pulse,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADED  = 2'd1,
        STALLED = 2'd2
    } state_t;

    state_t               state;
    logic                 hold_valid;
    logic [WORD_SIZE-1:0] hold_data;
    logic [1:0]           cls;
    logic                 accept;
    logic                 push_now;
    logic                 drop_now;
    logic [3:0]           push_q;
    logic [WORD_SIZE-1:0] dout_q [4];
    logic [CNT_WIDTH-1:0] cnt_q  [4];

    // State is a pure function of the holding register and the target FIFO's flag.
    always_comb begin
        cls      = hold_data[WORD_SIZE-1:WORD_SIZE-2];
        state    = EMPTY;
        if (hold_valid) begin
            state = fifos_almost_full[cls] ? STALLED : LOADED;
        end
        ready_out = (state != STALLED);
        accept    = valid_in & ready_out;
        push_now  = (state == LOADED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            push_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                dout_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            push_q <= '0;
            if (push_now) begin
                push_q[cls] <= 1'b1;
                dout_q[cls] <= hold_data;
                cnt_q[cls]  <= cnt_q[cls] + 1'b1;
            end
            // A new word overwrites the one leaving on the same edge, so no bubble.
            if (accept) begin
                hold_data  <= data_in;
                hold_valid <= 1'b1;
            end else if (push_now || drop_now) begin
                hold_valid <= 1'b0;
            end
        end
    end

`ifdef STALL_TIMEOUT_EN
    localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

    logic [SW-1:0] stall_cnt;
    logic          drop_q;

    assign drop_now = (state == STALLED) && (stall_cnt == SW'(STALL_LIMIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= drop_now;
            if ((state == STALLED) && !drop_now) begin
                stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end
        end
    end

    assign drop_pulse = drop_q;
`else
    assign drop_now   = 1'b0;
    assign drop_pulse = 1'b0;
`endif

    assign fifos_push     = push_q;
    assign fifo_data_out0 = dout_q[0];
    assign fifo_data_out1 = dout_q[1];
    assign fifo_data_out2 = dout_q[2];
    assign fifo_data_out3 = dout_q[3];
    assign push_count0    = cnt_q[0];
    assign push_count1    = cnt_q[1];
    assign push_count2    = cnt_q[2];
    assign push_count3    = cnt_q[3];
    assign idle           = !hold_valid && (push_q == 4'b0000);
    assign state_dbg      = state;

endmodule

// File: tb/tb_clasificador_escritor.sv
// Bench for clasificador_escritor: directed stimulus, expected pushes queued by the driver and popped by a monitor.
module tb_clasificador_escritor;

    localparam int W  = 12;
    localparam int CW = 8;

    logic          clk;
    logic          reset;
    logic [W-1:0]  data_in;
    logic          valid_in;
    logic          ready_out;
    logic [3:0]    fifos_almost_full;
    logic [3:0]    fifos_push;
    logic [W-1:0]  fifo_data_out0, fifo_data_out1, fifo_data_out2, fifo_data_out3;
    logic [CW-1:0] push_count0, push_count1, push_count2, push_count3;
    logic          idle;
    logic          drop_pulse;
    logic [1:0]    state_dbg;

    logic [W-1:0]  exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            w_cnt;

    clasificador_escritor #(.WORD_SIZE(W), .CNT_WIDTH(CW), .STALL_LIMIT(16)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .fifos_almost_full(fifos_almost_full),
        .fifos_push(fifos_push),
        .fifo_data_out0(fifo_data_out0), .fifo_data_out1(fifo_data_out1),
        .fifo_data_out2(fifo_data_out2), .fifo_data_out3(fifo_data_out3),
        .push_count0(push_count0), .push_count1(push_count1),
        .push_count2(push_count2), .push_count3(push_count3),
        .idle(idle), .drop_pulse(drop_pulse), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] dout_of(input logic [1:0] c);
        case (c)
            2'd0:    return fifo_data_out0;
            2'd1:    return fifo_data_out1;
            2'd2:    return fifo_data_out2;
            default: return fifo_data_out3;
        endcase
    endfunction

    // driver: hold word until accepted, optionally queue the expected push
    task automatic send(input logic [W-1:0] w, input bit expect_push, output int waits);
        data_in  = w;
        valid_in = 1'b1;
        waits    = 0;
        while (1) begin
            @(negedge clk);
            if (ready_out) break;
            waits++;
            if (waits > 100) begin
                check("send_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        if (expect_push) exp_q.push_back(w);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (idle && exp_q.size() == 0) break;
            n++;
            if (n > 50) begin
                check(name, 32'(exp_q.size()), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] w;
        if (reset && fifos_push != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_push", 32'(fifos_push), 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("push_onehot", 32'(fifos_push), 32'(4'b0001 << w[W-1:W-2]));
                check("push_data", 32'(dout_of(w[W-1:W-2])), 32'(w));
            end
        end
    end

    initial begin
        reset             = 1'b0;
        data_in           = '0;
        valid_in          = 1'b0;
        fifos_almost_full = 4'b0000;
        #12;
        check("rst_push", 32'(fifos_push), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_drop", 32'(drop_pulse), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        next_cycle();

        // back-to-back, one class each
        send(12'h0A5, 1'b1, w_cnt); check("b2b_wait0", 32'(w_cnt), 32'd0);
        send(12'h4B6, 1'b1, w_cnt); check("b2b_wait1", 32'(w_cnt), 32'd0);
        send(12'h8C7, 1'b1, w_cnt); check("b2b_wait2", 32'(w_cnt), 32'd0);
        send(12'hCD8, 1'b1, w_cnt); check("b2b_wait3", 32'(w_cnt), 32'd0);
        valid_in = 1'b0;
        wait_idle("b2b_drain");
        check("b2b_dout0", 32'(fifo_data_out0), 32'h0A5);
        check("b2b_dout1", 32'(fifo_data_out1), 32'h4B6);
        check("b2b_dout2", 32'(fifo_data_out2), 32'h8C7);
        check("b2b_dout3", 32'(fifo_data_out3), 32'hCD8);
        check("b2b_cnt", 32'({push_count3, push_count2, push_count1, push_count0}), 32'h01010101);

        // stall on class 1, release after 5 cycles
        fifos_almost_full = 4'b0010;
        send(12'h412, 1'b1, w_cnt);
        valid_in = 1'b0;
        @(negedge clk);
        check("stall_ready", 32'(ready_out), 32'd0);
        check("stall_nopush", 32'(fifos_push), 32'd0);
        check("stall_state", 32'(state_dbg), 32'd2);
        repeat (5) next_cycle();
        check("stall_hold_ready", 32'(ready_out), 32'd0);
        fifos_almost_full = 4'b0000;
        wait_idle("stall_drain");
        check("stall_cnt1", 32'(push_count1), 32'd2);
        check("stall_dout_keep0", 32'(fifo_data_out0), 32'h0A5);

        // offer a word while stalled: ignored until the stall clears
        fifos_almost_full = 4'b0001;
        send(12'h0A0, 1'b1, w_cnt);
        data_in  = 12'h0FF;
        valid_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("busy_ready", 32'(ready_out), 32'd0);
            check("busy_nopush", 32'(fifos_push), 32'd0);
        end
        next_cycle();
        fifos_almost_full = 4'b0000;
        send(12'h0FF, 1'b1, w_cnt);
        valid_in = 1'b0;
        wait_idle("busy_drain");
        check("busy_cnt0", 32'(push_count0), 32'd3);
        check("busy_dout0", 32'(fifo_data_out0), 32'h0FF);

        // asynchronous reset while a word is held
        fifos_almost_full = 4'b0001;
        send(12'h055, 1'b0, w_cnt);
        valid_in = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_idle", 32'(idle), 32'd1);
        check("arst_cnt", 32'({push_count3, push_count2, push_count1, push_count0}), 32'd0);
        check("arst_dout", 32'(fifo_data_out0 | fifo_data_out1 | fifo_data_out2 | fifo_data_out3), 32'd0);
        check("arst_ready", 32'(ready_out), 32'd1);
        next_cycle();
        reset             = 1'b1;
        fifos_almost_full = 4'b0000;
        repeat (4) next_cycle();
        check("arst_nopush_idle", 32'(idle), 32'd1);

        // 256 words of class 3 wrap the counter
        for (int i = 0; i < 256; i++) begin
            send(12'hC00 | 12'(i), 1'b1, w_cnt);
        end
        valid_in = 1'b0;
        wait_idle("wrap_drain");
        check("wrap_cnt3", 32'(push_count3), 32'd0);
        check("wrap_others", 32'({push_count2, push_count1, push_count0}), 32'd0);
        check("wrap_dout3", 32'(fifo_data_out3), 32'hCFF);
        check("wrap_drop", 32'(drop_pulse), 32'd0);

`ifdef STALL_TIMEOUT_EN
        fifos_almost_full = 4'b1111;
        send(12'hC01, 1'b0, w_cnt);
        valid_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("to_nodrop", 32'({drop_pulse, ready_out}), 32'd0);
        end
        @(negedge clk);
        check("to_drop", 32'(drop_pulse), 32'd1);
        check("to_ready", 32'(ready_out), 32'd1);
        check("to_cnt3", 32'(push_count3), 32'd0);
        @(negedge clk);
        check("to_drop_once", 32'(drop_pulse), 32'd0);
        fifos_almost_full = 4'b0000;
        repeat (3) next_cycle();
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
